// File: rtl/cpu_pkg.sv
// Shared decode definitions for the integer pipeline.
//   - RV32I major opcodes handled by the decode stage
//   - ALU operation encoding carried from ID into EX
//   - immediate-format select used between decode and imm_gen
//   - funct3_alu(): maps funct3 (+ alternate bit) onto the ALU op
package cpu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;

  typedef enum logic [3:0] {
    AluAdd   = 4'd0,
    AluSub   = 4'd1,
    AluSll   = 4'd2,
    AluSlt   = 4'd3,
    AluSltu  = 4'd4,
    AluXor   = 4'd5,
    AluSrl   = 4'd6,
    AluSra   = 4'd7,
    AluOr    = 4'd8,
    AluAnd   = 4'd9,
    AluPassB = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    ImmNone  = 3'd0,
    ImmI     = 3'd1,
    ImmS     = 3'd2,
    ImmU     = 3'd3,
    ImmShamt = 3'd4
  } imm_sel_e;

  // alt selects SUB over ADD and SRA over SRL; caller decides when it applies.
  function automatic alu_op_e funct3_alu(logic [2:0] funct3, logic alt);
    alu_op_e op;
    case (funct3)
      3'b000:  op = alt ? AluSub : AluAdd;
      3'b001:  op = AluSll;
      3'b010:  op = AluSlt;
      3'b011:  op = AluSltu;
      3'b100:  op = AluXor;
      3'b101:  op = alt ? AluSra : AluSrl;
      3'b110:  op = AluOr;
      default: op = AluAnd;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/id_decode_stage_if.sv
// Bus between IF/ID, the decode stage and EX.
//   ID side  : en, valid_in, instr, rs1_val_in, rs2_val_in, flush, wb_we/wb_rd/wb_data
//   back-edge: stall (combinational, to fetch)
//   EX side  : valid_ex, rs1_ex, rs2_ex, rs1_val_ex, rs2_val_ex, imm_ex, rd_ex,
//              reg_write_ex, alu_src_imm_ex, mem_we_ex, mem_re_ex, alu_op_ex, illegal_ex
// master: the surrounding pipeline; slave: the decode stage.
interface id_decode_stage_if #(
  parameter int unsigned D_WIDTH = 32,
  parameter int unsigned RF_SIZE = 5,
  parameter int unsigned OP_SIZE = 4
);

  logic               en;
  logic               valid_in;
  logic [D_WIDTH-1:0] instr;
  logic [D_WIDTH-1:0] rs1_val_in;
  logic [D_WIDTH-1:0] rs2_val_in;
  logic               flush;
  logic               wb_we;
  logic [RF_SIZE-1:0] wb_rd;
  logic [D_WIDTH-1:0] wb_data;

  logic               stall;

  logic               valid_ex;
  logic [RF_SIZE-1:0] rs1_ex;
  logic [RF_SIZE-1:0] rs2_ex;
  logic [D_WIDTH-1:0] rs1_val_ex;
  logic [D_WIDTH-1:0] rs2_val_ex;
  logic [D_WIDTH-1:0] imm_ex;
  logic [RF_SIZE-1:0] rd_ex;
  logic               reg_write_ex;
  logic               alu_src_imm_ex;
  logic               mem_we_ex;
  logic               mem_re_ex;
  logic [OP_SIZE-1:0] alu_op_ex;
  logic               illegal_ex;

  modport master (
    output en, valid_in, instr, rs1_val_in, rs2_val_in, flush, wb_we, wb_rd, wb_data,
    input  stall,
    input  valid_ex, rs1_ex, rs2_ex, rs1_val_ex, rs2_val_ex, imm_ex, rd_ex,
    input  reg_write_ex, alu_src_imm_ex, mem_we_ex, mem_re_ex, alu_op_ex, illegal_ex
  );

  modport slave (
    input  en, valid_in, instr, rs1_val_in, rs2_val_in, flush, wb_we, wb_rd, wb_data,
    output stall,
    output valid_ex, rs1_ex, rs2_ex, rs1_val_ex, rs2_val_ex, imm_ex, rd_ex,
    output reg_write_ex, alu_src_imm_ex, mem_we_ex, mem_re_ex, alu_op_ex, illegal_ex
  );

endinterface

// File: rtl/imm_gen.sv
// Immediate generator: forms the RV32I I/S/U immediates (and the zero-extended
// shift amount for immediate shifts) from an instruction word and returns the
// one chosen by sel_i. ImmNone yields zero.
//   instr_i : instruction word
//   sel_i   : immediate format select
//   imm_o   : selected immediate
module imm_gen
  import cpu_pkg::*;
(
  input  logic [XLEN-1:0] instr_i,
  input  imm_sel_e        sel_i,
  output logic [XLEN-1:0] imm_o
);

  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_sh;

  assign imm_i  = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s  = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_u  = {instr_i[31:12], 12'b0};
  assign imm_sh = {27'b0, instr_i[24:20]};

  always_comb begin
    imm_o = '0;
    case (sel_i)
      ImmI:     imm_o = imm_i;
      ImmS:     imm_o = imm_s;
      ImmU:     imm_o = imm_u;
      ImmShamt: imm_o = imm_sh;
      default:  imm_o = '0;
    endcase
  end

  // Opcode bits never contribute to an immediate.
  logic unused_opcode;
  assign unused_opcode = ^instr_i[6:0];

endmodule

// File: rtl/id_decode_stage.sv
// RV32I decode stage (OP, OP-IMM, LOAD/LW, STORE/SW, LUI) with load-use hazard
// detection and the ID/EX pipeline register.
//   clk, rst : rising-edge clock, synchronous active-high reset (beats en)
//   bus      : id_decode_stage_if slave; ID-side inputs, combinational stall back to
//              fetch, registered EX-side outputs (1-cycle latency)
// Optional build macro ID_WB_BYPASS_EN: capture write-back data into the operand
// registers when the write-back destination matches a source register. Without
// it the wb_* signals are ignored.
module id_decode_stage
  import cpu_pkg::*;
#(
  parameter int unsigned D_WIDTH = 32,
  parameter int unsigned N_REGS  = 32,
  parameter int unsigned RF_SIZE = $clog2(N_REGS),
  parameter int unsigned OP_SIZE = 4
) (
  input logic clk,
  input logic rst,
  id_decode_stage_if.slave bus
);

  typedef struct packed {
    logic               valid;
    logic [RF_SIZE-1:0] rs1;
    logic [RF_SIZE-1:0] rs2;
    logic [D_WIDTH-1:0] rs1_val;
    logic [D_WIDTH-1:0] rs2_val;
    logic [D_WIDTH-1:0] imm;
    logic [RF_SIZE-1:0] rd;
    logic               reg_write;
    logic               alu_src_imm;
    logic               mem_we;
    logic               mem_re;
    alu_op_e            alu_op;
    logic               illegal;
  } ex_t;

  ex_t ex_q, ex_d;

  // Instruction fields
  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic [6:0]         funct7;
  logic [RF_SIZE-1:0] rs1, rs2, rd;

  assign opcode = bus.instr[6:0];
  assign funct3 = bus.instr[14:12];
  assign funct7 = bus.instr[31:25];
  assign rd     = bus.instr[11:7];
  assign rs1    = bus.instr[19:15];
  assign rs2    = bus.instr[24:20];

  // Decode
  alu_op_e  dec_alu_op;
  logic     dec_reg_write, dec_alu_src_imm, dec_mem_we, dec_mem_re, dec_illegal;
  logic     rs1_used, rs2_used;
  imm_sel_e imm_sel;
  logic     is_shift;

  always_comb begin
    dec_alu_op      = AluAdd;
    dec_reg_write   = 1'b0;
    dec_alu_src_imm = 1'b0;
    dec_mem_we      = 1'b0;
    dec_mem_re      = 1'b0;
    dec_illegal     = 1'b0;
    rs1_used        = 1'b0;
    rs2_used        = 1'b0;
    imm_sel         = ImmNone;
    is_shift        = (funct3 == 3'b001) || (funct3 == 3'b101);

    case (opcode)
      OPC_OP: begin
        // Only ADD/SRL may take the 0100000 alternate form (SUB/SRA).
        if ((funct7 == 7'b0000000) ||
            ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)))) begin
          dec_alu_op    = funct3_alu(funct3, funct7[5]);
          dec_reg_write = 1'b1;
          rs1_used      = 1'b1;
          rs2_used      = 1'b1;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OPC_OPIMM: begin
        // For non-shifts funct7 is immediate bits, so no alternate form exists.
        if (!is_shift || (funct7 == 7'b0000000) ||
            ((funct3 == 3'b101) && (funct7 == 7'b0100000))) begin
          dec_alu_op      = funct3_alu(funct3, is_shift && funct7[5]);
          dec_reg_write   = 1'b1;
          dec_alu_src_imm = 1'b1;
          rs1_used        = 1'b1;
          imm_sel         = is_shift ? ImmShamt : ImmI;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OPC_LOAD: begin
        if (funct3 == 3'b010) begin
          dec_reg_write   = 1'b1;
          dec_alu_src_imm = 1'b1;
          dec_mem_re      = 1'b1;
          rs1_used        = 1'b1;
          imm_sel         = ImmI;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OPC_STORE: begin
        if (funct3 == 3'b010) begin
          dec_alu_src_imm = 1'b1;
          dec_mem_we      = 1'b1;
          rs1_used        = 1'b1;
          rs2_used        = 1'b1;
          imm_sel         = ImmS;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OPC_LUI: begin
        dec_alu_op      = AluPassB;
        dec_reg_write   = 1'b1;
        dec_alu_src_imm = 1'b1;
        imm_sel         = ImmU;
      end
      default: dec_illegal = 1'b1;
    endcase

    if (rd == '0) dec_reg_write = 1'b0;
  end

  logic [D_WIDTH-1:0] imm;

  imm_gen u_imm_gen (
    .instr_i (bus.instr),
    .sel_i   (imm_sel),
    .imm_o   (imm)
  );

  // Operand capture
  logic [D_WIDTH-1:0] rs1_val, rs2_val;

`ifdef ID_WB_BYPASS_EN
  // Register file reads the old value during a same-cycle write; take it from WB.
  always_comb begin
    rs1_val = bus.rs1_val_in;
    rs2_val = bus.rs2_val_in;
    if (bus.wb_we && (bus.wb_rd != '0) && (bus.wb_rd == rs1)) rs1_val = bus.wb_data;
    if (bus.wb_we && (bus.wb_rd != '0) && (bus.wb_rd == rs2)) rs2_val = bus.wb_data;
  end
`else
  assign rs1_val = bus.rs1_val_in;
  assign rs2_val = bus.rs2_val_in;

  logic unused_wb;
  assign unused_wb = ^{bus.wb_we, bus.wb_rd, bus.wb_data};
`endif

  // Load-use hazard against the load currently in EX
  logic rs1_hit, rs2_hit, stall;

  always_comb begin
    rs1_hit = rs1_used && (ex_q.rd == rs1);
    rs2_hit = rs2_used && (ex_q.rd == rs2);
    stall   = bus.valid_in && ex_q.valid && ex_q.mem_re && (ex_q.rd != '0) &&
              (rs1_hit || rs2_hit) && !bus.flush;
  end

  assign bus.stall = stall;

  // ID/EX register
  always_comb begin
    ex_d = ex_q;
    if (bus.en) begin
      if (bus.flush || stall || !bus.valid_in) begin
        ex_d = '0;
      end else begin
        ex_d.valid       = 1'b1;
        ex_d.rs1         = rs1;
        ex_d.rs2         = rs2;
        ex_d.rs1_val     = rs1_val;
        ex_d.rs2_val     = rs2_val;
        ex_d.imm         = imm;
        ex_d.rd          = rd;
        ex_d.reg_write   = dec_reg_write;
        ex_d.alu_src_imm = dec_alu_src_imm;
        ex_d.mem_we      = dec_mem_we;
        ex_d.mem_re      = dec_mem_re;
        ex_d.alu_op      = dec_alu_op;
        ex_d.illegal     = dec_illegal;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  assign bus.valid_ex       = ex_q.valid;
  assign bus.rs1_ex         = ex_q.rs1;
  assign bus.rs2_ex         = ex_q.rs2;
  assign bus.rs1_val_ex     = ex_q.rs1_val;
  assign bus.rs2_val_ex     = ex_q.rs2_val;
  assign bus.imm_ex         = ex_q.imm;
  assign bus.rd_ex          = ex_q.rd;
  assign bus.reg_write_ex   = ex_q.reg_write;
  assign bus.alu_src_imm_ex = ex_q.alu_src_imm;
  assign bus.mem_we_ex      = ex_q.mem_we;
  assign bus.mem_re_ex      = ex_q.mem_re;
  assign bus.alu_op_ex      = ex_q.alu_op;
  assign bus.illegal_ex     = ex_q.illegal;

endmodule

// File: tb/tb_id_decode_stage.sv
// Scoreboard bench for id_decode_stage: the driver computes expected behaviour
// from an instruction-level reference model and queues it; a monitor pops and
// compares the combinational stall and the registered EX outputs.
module tb_id_decode_stage;

  logic clk;
  logic rst;

  id_decode_stage_if #(.D_WIDTH(32), .RF_SIZE(5), .OP_SIZE(4)) bus ();

  id_decode_stage #(.D_WIDTH(32), .N_REGS(32), .RF_SIZE(5), .OP_SIZE(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          valid, illegal, rw, src, mwe, mre;
    logic [3:0]  op;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] v1, v2, imm;
    bit          c_rs1, c_rs2, c_rd, c_imm, c_all;
  } exp_t;

  exp_t ex_q[$];
  bit   stall_q[$];
  exp_t cur;
  bit   known = 0;

  int checks   = 0;
  int failures = 0;

  localparam logic [3:0] OPIMM_OP [8] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: decode one instruction as it should appear in EX.
  function automatic exp_t model_decode(logic [31:0] i, logic [31:0] a, logic [31:0] b,
                                        bit wwe, logic [4:0] wrd, logic [31:0] wd);
    exp_t e;
    bit   legal;
    logic [2:0] f3;
    logic [6:0] f7;
    bit   sh;
    e     = '{default: 0};
    f3    = i[14:12];
    f7    = i[31:25];
    e.valid = 1;
    e.rs1 = i[19:15];
    e.rs2 = i[24:20];
    e.rd  = i[11:7];
    e.v1  = a;
    e.v2  = b;
`ifdef ID_WB_BYPASS_EN
    if (wwe && wrd != 0 && wrd == i[19:15]) e.v1 = wd;
    if (wwe && wrd != 0 && wrd == i[24:20]) e.v2 = wd;
`else
    if (wwe && wrd == 5'd31 && wd == 32'hDEAD_BEEF) e.v1 = a; // wb inputs have no effect
`endif
    legal = 0;
    case (i[6:0])
      7'h33: begin
        legal = 1;
        case ({f7, f3})
          {7'h00, 3'd0}: e.op = 0;
          {7'h20, 3'd0}: e.op = 1;
          {7'h00, 3'd1}: e.op = 2;
          {7'h00, 3'd2}: e.op = 3;
          {7'h00, 3'd3}: e.op = 4;
          {7'h00, 3'd4}: e.op = 5;
          {7'h00, 3'd5}: e.op = 6;
          {7'h20, 3'd5}: e.op = 7;
          {7'h00, 3'd6}: e.op = 8;
          {7'h00, 3'd7}: e.op = 9;
          default:       legal = 0;
        endcase
        e.rw = 1; e.c_rs1 = 1; e.c_rs2 = 1; e.c_rd = 1;
      end
      7'h13: begin
        sh    = (f3 == 1) || (f3 == 5);
        legal = !sh || f7 == 0 || (f3 == 5 && f7 == 7'h20);
        e.op  = (f3 == 5 && f7 == 7'h20) ? 4'd7 : OPIMM_OP[f3];
        e.imm = sh ? ((i >> 20) & 32'h1F) : 32'($signed(i) >>> 20);
        e.rw = 1; e.src = 1; e.c_rs1 = 1; e.c_rd = 1; e.c_imm = 1;
      end
      7'h03: begin
        legal = (f3 == 2);
        e.imm = 32'($signed(i) >>> 20);
        e.rw = 1; e.src = 1; e.mre = 1; e.c_rs1 = 1; e.c_rd = 1; e.c_imm = 1;
      end
      7'h23: begin
        legal = (f3 == 2);
        e.imm = (32'($signed(i) >>> 20) & ~32'h1F) | ((i >> 7) & 32'h1F);
        e.mwe = 1; e.src = 1; e.c_rs1 = 1; e.c_rs2 = 1; e.c_imm = 1;
      end
      7'h37: begin
        legal = 1;
        e.op  = 4'd10;
        e.imm = i & 32'hFFFF_F000;
        e.rw = 1; e.src = 1; e.c_rd = 1; e.c_imm = 1;
      end
      default: legal = 0;
    endcase
    if (!legal) begin
      e.illegal = 1;
      e.rw = 0; e.src = 0; e.mwe = 0; e.mre = 0; e.op = 0;
      e.c_rs1 = 0; e.c_rs2 = 0; e.c_rd = 0; e.c_imm = 0;
    end
    if (e.rd == 0) e.rw = 0;
    return e;
  endfunction

  // Drive one cycle of ID inputs, predict stall and the next EX contents.
  task automatic step(input bit r, input bit e, input bit v, input bit f,
                      input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                      input bit wwe, input logic [4:0] wrd, input logic [31:0] wd,
                      output bit st);
    exp_t dec, nxt;
    rst            = r;
    bus.en         = e;
    bus.valid_in   = v;
    bus.flush      = f;
    bus.instr      = ins;
    bus.rs1_val_in = a;
    bus.rs2_val_in = b;
    bus.wb_we      = wwe;
    bus.wb_rd      = wrd;
    bus.wb_data    = wd;
    dec = model_decode(ins, a, b, wwe, wrd, wd);
    st  = v && cur.valid && cur.mre && cur.rd != 0 && !f &&
          ((cur.rd == ins[19:15] && dec.c_rs1) || (cur.rd == ins[24:20] && dec.c_rs2));
    if (known) stall_q.push_back(st);
    if (r) begin
      nxt = '{default: 0};
      nxt.c_all = 1;
      known = 1;
    end else if (!e) begin
      nxt = cur;
    end else if (f || st || !v) begin
      nxt = '{default: 0};
    end else begin
      nxt = dec;
    end
    if (known) ex_q.push_back(nxt);
    cur = nxt;
    @(posedge clk);
    #2;
  endtask

  task automatic go(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                    input bit f, output bit st);
    step(0, 1, 1, f, ins, a, b, 0, 5'd0, 32'd0, st);
  endtask

  function automatic logic [31:0] gen_instr();
    logic [6:0] f7, opc;
    logic [2:0] f3;
    logic [4:0] r1, r2, rd;
    int k;
    k  = $urandom_range(0, 9);
    r1 = 5'($urandom_range(0, 3));
    r2 = 5'($urandom_range(0, 3));
    rd = 5'($urandom_range(0, 3));
    f3 = 3'($urandom_range(0, 7));
    f7 = ($urandom_range(0, 3) == 0) ? 7'($urandom) : (($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00);
    case (k)
      0, 1:    opc = 7'h33;
      2, 3:    begin opc = 7'h13; if (f3 != 1 && f3 != 5) f7 = 7'($urandom); end
      4, 5:    begin opc = 7'h03; f3 = ($urandom_range(0, 3) == 0) ? f3 : 3'd2; f7 = 7'($urandom); end
      6:       begin opc = 7'h23; f3 = ($urandom_range(0, 3) == 0) ? f3 : 3'd2; f7 = 7'($urandom); end
      7:       begin opc = 7'h37; f7 = 7'($urandom); end
      8:       return $urandom;
      default: opc = 7'($urandom);
    endcase
    return {f7, r2, r1, f3, rd, opc};
  endfunction

  // Monitor
  initial begin
    exp_t e;
    bit   s;
    forever begin
      @(posedge clk);
      #1;
      if (ex_q.size() > 0) begin
        e = ex_q.pop_front();
        chk("valid_ex", bus.valid_ex, e.valid);
        chk("illegal_ex", bus.illegal_ex, e.illegal);
        chk("reg_write_ex", bus.reg_write_ex, e.rw);
        chk("alu_src_imm_ex", bus.alu_src_imm_ex, e.src);
        chk("mem_we_ex", bus.mem_we_ex, e.mwe);
        chk("mem_re_ex", bus.mem_re_ex, e.mre);
        chk("alu_op_ex", bus.alu_op_ex, e.op);
        if (e.c_all || e.c_rs1) begin
          chk("rs1_ex", bus.rs1_ex, e.rs1);
          chk("rs1_val_ex", bus.rs1_val_ex, e.v1);
        end
        if (e.c_all || e.c_rs2) begin
          chk("rs2_ex", bus.rs2_ex, e.rs2);
          chk("rs2_val_ex", bus.rs2_val_ex, e.v2);
        end
        if (e.c_all || e.c_rd) chk("rd_ex", bus.rd_ex, e.rd);
        if (e.c_all || e.c_imm) chk("imm_ex", bus.imm_ex, e.imm);
      end
      @(negedge clk);
      if (stall_q.size() > 0) begin
        s = stall_q.pop_front();
        chk("stall", bus.stall, s);
      end
    end
  end

  // Stimulus
  localparam logic [31:0] I_ADDI_M3 = 32'hFFD0_0293;  // addi x5,x0,-3
  localparam logic [31:0] I_SUB     = 32'h4020_81B3;  // sub  x3,x1,x2
  localparam logic [31:0] I_LW      = 32'h0080_A303;  // lw   x6,8(x1)
  localparam logic [31:0] I_ADD_DEP = 32'h0023_03B3;  // add  x7,x6,x2
  localparam logic [31:0] I_ADD_X1  = 32'h0020_81B3;  // add  x3,x1,x2
  localparam logic [31:0] I_BAD     = 32'h0000_007F;
  localparam logic [31:0] I_ADDI_X0 = 32'h0010_0013;  // addi x0,x0,1

  initial begin
    bit st, hold, r_v, e_v, f_v, v_v, wwe;
    logic [31:0] ins, a, b, wd;
    logic [4:0]  wrd;
    int guard;
    cur  = '{default: 0};
    rst  = 1'b1;
    hold = 0;
    ins = 0; a = 0; b = 0; v_v = 0;
    @(posedge clk);
    #2;

    step(1, 1, 1, 0, I_ADDI_M3, 32'd7, 32'd9, 0, 5'd0, 32'd0, st);
    step(1, 1, 1, 0, I_ADDI_M3, 32'd7, 32'd9, 0, 5'd0, 32'd0, st);
    chk("reset_valid_ex", bus.valid_ex, 0);

    go(I_ADDI_M3, 32'd0, 32'd0, 0, st);
    chk("addi_imm", bus.imm_ex, 32'hFFFF_FFFD);
    chk("addi_rd", bus.rd_ex, 5);

    go(I_SUB, 32'd10, 32'd4, 0, st);
    chk("sub_alu_op", bus.alu_op_ex, 1);
    chk("sub_rs2_val", bus.rs2_val_ex, 4);

    // Load-use: one stall cycle, one bubble, then the consumer proceeds.
    go(I_LW, 32'h100, 32'd0, 0, st);
    go(I_ADD_DEP, 32'd1, 32'd2, 0, st);
    chk("lu_bubble_valid", bus.valid_ex, 0);
    chk("lu_stall_release", bus.stall, 0);
    go(I_ADD_DEP, 32'd1, 32'd2, 0, st);
    chk("lu_add_rd", bus.rd_ex, 7);

    // Flush wins over a pending load-use stall.
    go(I_LW, 32'h100, 32'd0, 0, st);
    go(I_ADD_DEP, 32'd1, 32'd2, 1, st);
    chk("flush_valid", bus.valid_ex, 0);

    // Reset in the middle of a stall clears EX.
    go(I_LW, 32'h100, 32'd0, 0, st);
    step(1, 1, 1, 0, I_ADD_DEP, 32'd1, 32'd2, 0, 5'd0, 32'd0, st);
    chk("rst_stall_release", bus.stall, 0);
    go(I_ADD_DEP, 32'd1, 32'd2, 0, st);

    go(I_BAD, 32'd0, 32'd0, 0, st);
    chk("illegal_flag", bus.illegal_ex, 1);
    go(I_ADDI_X0, 32'd0, 32'd0, 0, st);
    chk("x0_reg_write", bus.reg_write_ex, 0);

    // en=0 holds everything
    step(0, 0, 1, 0, I_SUB, 32'd3, 32'd3, 0, 5'd0, 32'd0, st);

    step(0, 1, 1, 0, I_ADD_X1, 32'd0, 32'd4, 1, 5'd1, 32'h55, st);
`ifdef ID_WB_BYPASS_EN
    chk("bypass_rs1", bus.rs1_val_ex, 32'h55);
`else
    chk("no_bypass_rs1", bus.rs1_val_ex, 32'h0);
`endif

    // Randomized traffic; IF/ID holds its instruction while stalled or disabled.
    for (int n = 0; n < 3000; n++) begin
      r_v = ($urandom_range(0, 99) == 0);
      e_v = ($urandom_range(0, 9) != 0);
      f_v = ($urandom_range(0, 15) == 0);
      if (!hold) begin
        v_v = ($urandom_range(0, 7) != 0);
        ins = gen_instr();
        a   = $urandom;
        b   = $urandom;
      end
      wwe = $urandom_range(0, 1) == 1;
      wrd = 5'($urandom_range(0, 3));
      wd  = $urandom;
      step(r_v, e_v, v_v, f_v, ins, a, b, wwe, wrd, wd, st);
      hold = !r_v && (!e_v || (st && !f_v));
    end

    guard = 0;
    while ((ex_q.size() > 0 || stall_q.size() > 0) && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    if (ex_q.size() > 0 || stall_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expectations left, required 0", ex_q.size() + stall_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_decode_stage.md
Name: id_decode_stage

Overview:
- Second-generation decode stage: full RV32I integer decode for OP, OP-IMM, LOAD, STORE and LUI, replacing the ADDI-only decoder.
- Extracts register fields from `instr` internally, generates immediates, and detects load-use hazards.
- Inserts bubbles on stall or flush, and carries a valid bit into the ID/EX pipeline register.
- Sits between IF/ID register and EX stage; drives `stall` back to fetch.

Parameters:
- D_WIDTH, 32, datapath and instruction width (must be 32).
- N_REGS, 32, architectural register count.
- RF_SIZE, $clog2(N_REGS), register index width.
- OP_SIZE, 4, ALU op code width.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- en  input  1  global advance enable; when 0, all EX registers hold
- valid_in  input  1  instr from IF/ID is valid
- instr  input  D_WIDTH  instruction word
- rs1_val_in  input  D_WIDTH  register-file read data for instr[19:15]
- rs2_val_in  input  D_WIDTH  register-file read data for instr[24:20]
- flush  input  1  squash the instruction currently in ID (taken branch in EX)
- wb_we  input  1  write-back write enable (used only with ID_WB_BYPASS_EN)
- wb_rd  input  RF_SIZE  write-back destination
- wb_data  input  D_WIDTH  write-back data
- stall  output  1  combinational; IF and IF/ID must hold when 1
- valid_ex  output  1  EX slot holds a real instruction
- rs1_ex, rs2_ex  output  RF_SIZE  source indices for EX forwarding
- rs1_val_ex, rs2_val_ex  output  D_WIDTH  operand values
- imm_ex  output  D_WIDTH  sign- or zero-formed immediate
- rd_ex  output  RF_SIZE  destination index
- reg_write_ex, alu_src_imm_ex, mem_we_ex, mem_re_ex  output  1  control
- alu_op_ex  output  OP_SIZE  ALU operation
- illegal_ex  output  1  unsupported encoding in EX slot

Behaviour:
- Reset: on posedge clk with rst=1, every registered output is set to 0. This takes priority over en.
- Latency: 1 cycle. ID inputs on edge N appear on the EX outputs after edge N.
- Decode (combinational):
  - OP (0110011): funct3/funct7 select ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND. reg_write=1.
  - OP-IMM (0010011): I-immediate `{{20{i[31]}},i[31:20]}`. Shifts use shamt i[24:20]; funct7 must be 0000000, or 0100000 for SRAI. alu_src_imm=1, reg_write=1.
  - LOAD (0000011), funct3=010 only: ADD, imm I, mem_re=1, reg_write=1.
  - STORE (0100011), funct3=010 only: ADD, S-immediate `{{20{i[31]}},i[31:25],i[11:7]}`, mem_we=1.
  - LUI (0110111): imm `{i[31:12],12'b0}`, alu_op PASSB, alu_src_imm=1, reg_write=1.
  - Any other encoding: illegal=1, all writes 0.
  - rd=0 forces reg_write=0.
- Source use: rs1 is used by all classes except LUI. rs2 is used by OP and STORE.
- Hazard: stall = valid_in & valid_ex & mem_re_ex & (rd_ex≠0) & ((rd_ex==rs1 & rs1 used) | (rd_ex==rs2 & rs2 used)) & ~flush.
- Update when en=1, in priority order:
  - flush=1 → bubble.
  - Else stall=1 → bubble; the ID instruction stays presented by IF/ID.
  - Else valid_in=0 → bubble.
  - Else load decoded fields; valid_ex=1.
- Bubble means valid_ex=0 and all control outputs plus illegal_ex set to 0. Data fields are don't-care and are set to 0.
- en=0: all EX registers hold. stall is still computed from current values.
- Reset mid-stall: clears valid_ex, so stall deasserts the next cycle.

Optional Feature:
- Macro ID_WB_BYPASS_EN.
- Defined: if wb_we & wb_rd≠0 & wb_rd==rs1, rs1_val_ex captures wb_data instead of rs1_val_in. rs2 behaves the same way. This covers a register file without write-first read.
- Undefined: wb_* ports exist but are ignored; operands come only from rs*_val_in.

Decomposition:
- Package `cpu_pkg`:
  - opcode localparams (OPC_OP, OPC_OPIMM, OPC_LOAD, OPC_STORE, OPC_LUI).
  - ALU op encoding: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, PASSB=10.
- Sub-module `imm_gen`: combinational, instr → I/S/U immediates plus select.
- Decode and hazard logic stay in the top module.

Test Plan:
- Reset: rst=1 for 2 cycles with valid_in=1 → all outputs 0. Release, then ADDI x5,x0,-3 (0xFFD00293) → imm_ex=0xFFFFFFFD, rd_ex=5, alu_op=0, alu_src_imm=1, valid_ex=1.
- R-type: SUB x3,x1,x2 (0x402081B3) with rs1_val_in=10, rs2_val_in=4 → alu_op=1, reg_write=1, alu_src_imm=0, operands 10/4.
- Load-use: LW x6,8(x1) followed by ADD x7,x6,x2 → stall=1 for exactly one cycle, then a bubble (valid_ex=0); ADD enters EX the next cycle.
- Flush priority: flush=1 during a load-use stall → valid_ex=0 and stall=0 the same cycle.
- Illegal and x0 cases: instr 0x0000007F → illegal_ex=1, reg_write_ex=0. ADDI x0,x0,1 → reg_write_ex=0.
- With ID_WB_BYPASS_EN: wb_we=1, wb_rd=1, wb_data=0x55 while ADD reads x1 with rs1_val_in=0 → rs1_val_ex=0x55.
